led_flow_top: RTL and testbench
===============================

Name: led_flow_top

Overview:
- Top-level running-light ("LED flow") block for the board LED bank.
- Divides the 50 MHz system clock down to a step tick (1 Hz by default).
- Rotates a single lit LED across a 4-bit output, advancing one position per tick.
- Sits directly under the board pin-out; no bus interface.

Parameters:
- CLK_FREQ, 50_000_000, input clock frequency in Hz.
- STEP_HZ, 1, LED step rate in Hz.
- LED_W, 4, number of LEDs driven.
- DIV, CLK_FREQ/STEP_HZ (derived localparam), clock cycles per step. Must be ≥ 2; elaboration error otherwise.

Ports:
- clk  input  1  system clock, 50 MHz (20 ns period); all logic on rising edge.
- rst  input  1  asynchronous, active-high reset; release is sampled synchronously.
- top_led_flow  output  LED_W  LED drive pattern, active-high, registered output.

Behaviour:
- Divider counter
  - Width is ceil(log2(DIV)); 26 bits at default.
  - Counts 0..DIV-1 and wraps to 0.
  - Internal step pulse `tick` is asserted for exactly one cycle when the counter equals DIV-1.
- LED register
  - On each cycle with `tick`=1, top_led_flow rotates left by one: bit i moves to bit i+1, and the MSB wraps to the LSB.
  - Default sequence: 0001 → 0010 → 0100 → 1000 → 0001 → …
  - Holds its value on cycles without `tick`.
- Reset
  - While rst=1: counter=0, tick=0, top_led_flow = 1 in the LSB, others 0 (4'b0001).
  - Takes effect immediately, without waiting for a clock edge.
  - Reset mid-sequence returns the output to 4'b0001 and restarts the divider from 0.
- Latency
  - The first rising edge after rst deasserts is counter cycle 0.
  - The first output change (0001→0010) occurs on the DIV-th rising edge after reset release.
  - At default parameters that is 1,000,000,000 ns (1 s) after release.
  - Each subsequent change follows exactly DIV cycles later.
- Invariant: exactly one bit of top_led_flow is high at all times, including immediately after reset.
- Wrap-around
  - The counter wraps silently with no overflow flag.
  - The LED pattern wraps MSB→LSB with no dead cycle.
- No glitches: the output is driven directly from flops and is never combinationally decoded.
- No other state and no other outputs.

Test Plan:
- Reset hold: rst=1 for 2 cycles, clock running → top_led_flow=4'b0001 and counter=0 throughout; assert rst asynchronously mid-cycle → output goes to 0001 before the next edge.
- First step timing (CLK_FREQ=10, STEP_HZ=1, DIV=10): release rst → output stays 0001 for edges 1–9 and becomes 0010 on edge 10.
- Full rotation (DIV=10): run 40 edges after release → output reads 0010, 0100, 1000, 0001 at edges 10, 20, 30, 40; one-hot checked on every cycle.
- Reset mid-sequence: with output at 0100 and counter at 5, pulse rst for 1 cycle → output 0001 and counter 0; next change to 0010 occurs exactly 10 edges after release.
- Default parameters (50 MHz, 20 ns period, rst released at 20 ns): output 0001 until 1,000,000,020 ns, then 0010; shorten via defparam in regression if runtime is too long.
- Long run (DIV=3, 1000 steps): pattern period is exactly 4 ticks = 12 cycles, with no missed or double steps.

Source files
------------

// File: rtl/led_flow_top.sv
// Running-light LED driver: a clock divider produces a one-cycle step tick,
// and each tick rotates a single lit LED one position towards the MSB.
module led_flow_top #(
   parameter int unsigned CLK_FREQ = 50_000_000,
   parameter int unsigned STEP_HZ  = 1,
   parameter int unsigned LED_W    = 4
) (
   input  logic             clk,
   input  logic             rst,
   output logic [LED_W-1:0] top_led_flow
);

   localparam int unsigned DIV   = CLK_FREQ / STEP_HZ;
   localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DIV - 1);
   localparam logic [LED_W-1:0] LED_INIT = LED_W'(1);

   generate
      if (DIV < 2) begin : g_bad_div
         $error("led_flow_top: CLK_FREQ/STEP_HZ must be at least 2");
      end
      if (LED_W < 1) begin : g_bad_led_w
         $error("led_flow_top: LED_W must be at least 1");
      end
   endgenerate

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [LED_W-1:0] led_q, led_d;
   logic             tick;

   // The counter idles at 0 during reset, so tick is low there because DIV >= 2.
   always_comb begin
      tick  = (cnt_q == CNT_MAX);
      cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
      led_d = led_q;
      if (tick) begin
         for (int unsigned i = 0; i < LED_W; i++) begin
            led_d[(i + 1) % LED_W] = led_q[i];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
         led_q <= LED_INIT;
      end else begin
         cnt_q <= cnt_d;
         led_q <= led_d;
      end
   end

   assign top_led_flow = led_q;

endmodule

// File: tb/tb_led_flow_top.sv
// Scoreboard bench for led_flow_top: a DIV=10 instance for timing/reset cases
// and a DIV=3 instance for a 1000-step long run.
module tb_led_flow_top;

   typedef struct {
      string      name;
      bit         sel_b;
      logic [3:0] exp;
   } exp_t;

   logic       clk;
   logic       rst_a, rst_b;
   logic [3:0] led_a, led_b;
   logic       done;
   int         checks;
   int         errors;
   exp_t       sb_q[$];
   logic [3:0] tab [4];

   led_flow_top #(.CLK_FREQ(10), .STEP_HZ(1), .LED_W(4)) dut_a (
      .clk          (clk),
      .rst          (rst_a),
      .top_led_flow (led_a)
   );

   led_flow_top #(.CLK_FREQ(3), .STEP_HZ(1), .LED_W(4)) dut_b (
      .clk          (clk),
      .rst          (rst_b),
      .top_led_flow (led_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic bit is_onehot(input logic [3:0] v);
      return (v != 4'b0000) && ((v & (v - 4'b0001)) == 4'b0000);
   endfunction

   task automatic push(input string name, input bit sel_b, input logic [3:0] exp);
      exp_t e;
      e.name  = name;
      e.sel_b = sel_b;
      e.exp   = exp;
      sb_q.push_back(e);
   endtask

   // Stimulus: every push is the hand-derived output expected before the next edge.
   initial begin
      tab[0] = 4'b0001;
      tab[1] = 4'b0010;
      tab[2] = 4'b0100;
      tab[3] = 4'b1000;
      done  = 1'b0;
      rst_a = 1'b1;
      rst_b = 1'b1;

      repeat (2) begin
         @(posedge clk);
         push("reset_hold", 1'b0, 4'b0001);
      end
      #1 rst_a = 1'b0;

      for (int e = 1; e <= 64; e++) begin
         @(posedge clk);
         push((e % 10 == 0) ? "step_edge" : "hold", 1'b0, tab[(e / 10) % 4]);
      end

      // Edge 65: output 0100 with the counter at 5; reset lands mid-cycle.
      @(posedge clk);
      #2 rst_a = 1'b1;
      push("async_reset", 1'b0, 4'b0001);
      @(posedge clk);
      push("reset_mid", 1'b0, 4'b0001);
      #1 rst_a = 1'b0;

      for (int e = 1; e <= 12; e++) begin
         @(posedge clk);
         push((e % 10 == 0) ? "restart_step" : "restart_hold", 1'b0, tab[(e / 10) % 4]);
      end

      @(posedge clk);
      push("b_reset", 1'b1, 4'b0001);
      #1 rst_b = 1'b0;

      for (int e = 1; e <= 3000; e++) begin
         @(posedge clk);
         push("long_run", 1'b1, tab[(e / 3) % 4]);
      end

      @(posedge clk);
      #1 done = 1'b1;
   end

   // Monitor: samples on the falling edge, away from the active edge.
   initial begin
      checks = 0;
      errors = 0;
      forever begin
         @(negedge clk);
         checks++;
         if (!is_onehot(led_a)) begin
            errors++;
            $display("FAIL onehot_a: got %b required exactly one bit set", led_a);
         end
         checks++;
         if (!is_onehot(led_b)) begin
            errors++;
            $display("FAIL onehot_b: got %b required exactly one bit set", led_b);
         end
         while (sb_q.size() > 0) begin
            exp_t       e;
            logic [3:0] act;
            e   = sb_q.pop_front();
            act = e.sel_b ? led_b : led_a;
            checks++;
            if (act !== e.exp) begin
               errors++;
               $display("FAIL %s: got %b required %b at %0t", e.name, act, e.exp, $time);
            end
         end
         if (done) begin
            $display("Result: errors=%0d of %0d checks", errors, checks);
            $finish;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1, "watchdog expired");
   end

endmodule
